display_timings: RTL and testbench
==================================

// Module: display_timings
// PURPOSE
// - VGA raster timing generator for the text-mode video block; default mode is 640x480@60 (800x525 total).
// - Runs on the pixel clock: ~25.1 MHz, derived as the PLL output (CLK_FAST) divided by 4 in the parent.
// - Emits sync pulses, a data-enable flag and the current raster coordinates.
// - Coordinates drive character-RAM/ROM address generation; vsync also clocks the cursor blink counter.
// PARAMETERS
// - H_RES 640: active pixels per line.
// - H_FP 16: horizontal front porch, in pixels.
// - H_SYNC 96: hsync pulse width, in pixels.
// - H_BP 48: horizontal back porch; line total = H_RES+H_FP+H_SYNC+H_BP = 800.
// - V_RES 480: active lines per frame.
// - V_FP 10: vertical front porch, in lines.
// - V_SYNC 2: vsync pulse width, in lines.
// - V_BP 33: vertical back porch; frame total = 525 lines.
// - H_POL 0: hsync asserted level (0 = active-low).
// - V_POL 0: vsync asserted level (0 = active-low).
// PORTS
// - clk_pix  in   1   pixel clock; the only clock in this block.
// - rst      in   1   reset; synchronous, active-low.
// - hsync    out  1   horizontal sync, registered, glitch-free.
// - vsync    out  1   vertical sync, registered, glitch-free.
// - de       out  1   data enable; 1 only while inside the active area.
// - sx       out  10  current column, 0..799.
// - sy       out  10  current line, 0..524.
// BEHAVIOUR
// - Counters
//   - All outputs are registered.
//   - sx increments by 1 on every clk_pix edge.
//   - When sx == H_TOTAL-1 (799): sx wraps to 0 and sy increments on the same edge.
//   - When sy == V_TOTAL-1 (524) and sx wraps: sy also wraps to 0.
// - Alignment: hsync, vsync and de always describe the (sx,sy) value presented in the same cycle (zero skew).
//   - Implement by decoding next-state counter values into the output registers.
// - de = (sx < H_RES) && (sy < V_RES).
// - hsync asserted (== H_POL) for sx in [H_RES+H_FP, H_RES+H_FP+H_SYNC-1] = 656..751; otherwise !H_POL.
// - vsync asserted (== V_POL) for sy in [V_RES+V_FP, V_RES+V_FP+V_SYNC-1] = 490..491, for every sx of those lines; otherwise !V_POL.
//   - vsync therefore changes only on the sx 799->0 boundary.
// - Reset (rst low, sampled at the clk_pix edge)
//   - Next state: sx=0, sy=0, de=1, hsync=!H_POL, vsync=!V_POL.
//   - Held low: outputs hold those values.
//   - Asserted mid-frame: counters abandon the current position immediately; no partial sync pulse continues.
//   - First edge with rst high: sx=1, sy=0.
// - Counter widths: 10 bits; totals must be <= 1024 per axis. Counters never exceed total-1 (no out-of-range states).
// - Frame period: 800*525 = 420000 clk_pix cycles. Line period: 800 cycles.
// - Companion pll (hard IP wrapper, not part of this RTL)
//   - Ports: clock_in 12 MHz, clock_out ~100.5 MHz, locked, reset (active-low).
//   - The parent holds this block in reset until locked.
// TESTING
// - Reset release: hold rst=0 for 5 clocks, then release.
//   - -> sx=0, sy=0, de=1, hsync=1, vsync=1 during reset; sx=1 on the first edge after release.
// - Line timing: run one line from sx=0.
//   - -> de=1 for sx 0..639 (640 cycles), 0 for 640..799.
//   - -> hsync=0 exactly for sx 656..751 (96 cycles).
//   - -> sx 799 is followed by sx=0, sy+1.
// - Frame timing: run 420000 cycles.
//   - -> vsync=0 exactly for sy 490..491 (1600 cycles).
//   - -> de=0 for all sy >= 480.
//   - -> (799,524) is followed by (0,0).
// - Periodicity: measure edge-to-edge intervals.
//   - -> hsync falling-edge spacing is 800 cycles.
//   - -> vsync falling-edge spacing is 420000 cycles; no extra edges (glitch check).
// - Mid-frame reset: pulse rst=0 for 1 cycle at (sx,sy)=(700,491), while both syncs are asserted.
//   - -> the next state is (0,0), with hsync=1 and vsync=1 immediately.
// - Parameter override: H_RES=320, H_FP=8, H_SYNC=48, H_BP=24, H_POL=1.
//   - -> line total is 400 cycles.
//   - -> hsync=1 exactly for sx 328..375.

Source files
------------

// File: rtl/display_timings.sv
// Purpose: VGA raster timing generator (sync pulses, data enable, raster coordinates).
// Latency: all outputs registered; sync/de decoded from next-state counters, so zero skew vs sx/sy.
// Backpressure: none; free-running on every clk_pix edge, only rst interrupts the raster.
module display_timings #(
   parameter int   H_RES  = 640,
   parameter int   H_FP   = 16,
   parameter int   H_SYNC = 96,
   parameter int   H_BP   = 48,
   parameter int   V_RES  = 480,
   parameter int   V_FP   = 10,
   parameter int   V_SYNC = 2,
   parameter int   V_BP   = 33,
   parameter logic H_POL  = 1'b0,
   parameter logic V_POL  = 1'b0
) (
   input  logic       clk_pix,
   input  logic       rst,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic [9:0] sx,
   output logic [9:0] sy
);

   localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

   // Counter limits and decode thresholds, pre-sized to the 10-bit counters.
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_RES);
   localparam logic [9:0] V_ACT    = 10'(V_RES);
   localparam logic [9:0] HS_FIRST = 10'(H_RES + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_RES + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_RES + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_RES + V_FP + V_SYNC - 1);

   // A raster larger than the counters could address would silently alias.
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("display_timings: raster total exceeds 10-bit counter range");
   end

   logic [9:0] sx_nxt;
   logic [9:0] sy_nxt;
   logic       de_nxt;
   logic       hsync_nxt;
   logic       vsync_nxt;

   // Next raster position: sx wraps at line end, sy steps on that same edge and wraps at frame end.
   always_comb begin
      sx_nxt = sx + 10'd1;
      sy_nxt = sy;
      if (sx == H_LAST) begin
         sx_nxt = 10'd0;
         if (sy == V_LAST) begin
            sy_nxt = 10'd0;
         end else begin
            sy_nxt = sy + 10'd1;
         end
      end
   end

   // Decode the next position so the registered flags line up with the registered coordinates.
   always_comb begin
      de_nxt    = (sx_nxt < H_ACT) && (sy_nxt < V_ACT);
      hsync_nxt = ((sx_nxt >= HS_FIRST) && (sx_nxt <= HS_LAST)) ? H_POL : ~H_POL;
      vsync_nxt = ((sy_nxt >= VS_FIRST) && (sy_nxt <= VS_LAST)) ? V_POL : ~V_POL;
   end

   // Output registers; reset snaps straight to the origin with both syncs idle.
   always_ff @(posedge clk_pix) begin
      if (!rst) begin
         sx    <= 10'd0;
         sy    <= 10'd0;
         de    <= 1'b1;
         hsync <= ~H_POL;
         vsync <= ~V_POL;
      end else begin
         sx    <= sx_nxt;
         sy    <= sy_nxt;
         de    <= de_nxt;
         hsync <= hsync_nxt;
         vsync <= vsync_nxt;
      end
   end

endmodule

// File: tb/tb_display_timings.sv
module tb_display_timings;

   logic clk_pix = 1'b0;
   logic rst_a   = 1'b0;   // default-mode and half-width instances
   logic rst_b   = 1'b0;   // short-frame instance (mid-frame reset target)

   always #5 clk_pix = ~clk_pix;

   // Default 640x480 mode.
   logic       hs_a, vs_a, de_a;
   logic [9:0] sx_a, sy_a;
   display_timings u_dflt (
      .clk_pix(clk_pix), .rst(rst_a), .hsync(hs_a), .vsync(vs_a),
      .de(de_a), .sx(sx_a), .sy(sy_a)
   );

   // Short frame: 19 lines of 800, vsync on lines 14..15, de only on lines 0..11.
   logic       hs_b, vs_b, de_b;
   logic [9:0] sx_b, sy_b;
   display_timings #(.V_RES(12), .V_FP(2), .V_SYNC(2), .V_BP(3)) u_small (
      .clk_pix(clk_pix), .rst(rst_b), .hsync(hs_b), .vsync(vs_b),
      .de(de_b), .sx(sx_b), .sy(sy_b)
   );

   // Horizontal override: 400-pixel line, active-high hsync on 328..375.
   logic       hs_c, vs_c, de_c;
   logic [9:0] sx_c, sy_c;
   display_timings #(.H_RES(320), .H_FP(8), .H_SYNC(48), .H_BP(24), .H_POL(1'b1)) u_half (
      .clk_pix(clk_pix), .rst(rst_a), .hsync(hs_c), .vsync(vs_c),
      .de(de_c), .sx(sx_c), .sy(sy_c)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Measurements taken while stepping.
   int de_cnt = 0, hs_low_cnt = 0, hs_high_cnt_c = 0;
   int n_hfall = 0, bad_hgap = 0, last_hfall = -1;
   int n_vfall = 0, n_vrise = 0, vfall0 = -1, vfall1 = -1;
   int vs_low_cnt = 0, de_bad = 0;

   localparam int MEAS_END = 30400;   // two short frames

   typedef struct {
      int t;     // cycles since reset release
      int sel;   // 0 = u_dflt, 1 = u_half, 2 = u_small
      int sx;
      int sy;
      bit de;
      bit hs;
      bit vs;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs[NV];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      bit phs = hs_a;
      bit pvs = vs_b;
      @(posedge clk_pix);
      #1;
      cyc++;
      if (cyc >= 800 && cyc < 1600) begin
         if (de_a)  de_cnt++;
         if (!hs_a) hs_low_cnt++;
      end
      if (cyc >= 400 && cyc < 800 && hs_c) hs_high_cnt_c++;
      if (cyc < MEAS_END) begin
         if (phs && !hs_a) begin
            if (last_hfall >= 0 && (cyc - last_hfall) != 800) bad_hgap++;
            last_hfall = cyc;
            n_hfall++;
         end
         if (pvs && !vs_b) begin
            if (n_vfall == 0) vfall0 = cyc;
            if (n_vfall == 1) vfall1 = cyc;
            n_vfall++;
         end
         if (!pvs && vs_b) n_vrise++;
         if (cyc >= 15200 && !vs_b) vs_low_cnt++;
         if (de_b && sy_b >= 10'd12) de_bad++;
      end
   endtask

   initial begin
      int a_sx, a_sy, a_de, a_hs, a_vs;

      //                t      sel  sx   sy  de hs vs
      vecs[0]  = '{    1,  0,   1,   0, 1, 1, 1};
      vecs[1]  = '{    1,  1,   1,   0, 1, 0, 1};
      vecs[2]  = '{  319,  1, 319,   0, 1, 0, 1};
      vecs[3]  = '{  320,  1, 320,   0, 0, 0, 1};
      vecs[4]  = '{  327,  1, 327,   0, 0, 0, 1};
      vecs[5]  = '{  328,  1, 328,   0, 0, 1, 1};
      vecs[6]  = '{  375,  1, 375,   0, 0, 1, 1};
      vecs[7]  = '{  376,  1, 376,   0, 0, 0, 1};
      vecs[8]  = '{  399,  1, 399,   0, 0, 0, 1};
      vecs[9]  = '{  400,  1,   0,   1, 1, 0, 1};
      vecs[10] = '{  639,  0, 639,   0, 1, 1, 1};
      vecs[11] = '{  640,  0, 640,   0, 0, 1, 1};
      vecs[12] = '{  655,  0, 655,   0, 0, 1, 1};
      vecs[13] = '{  656,  0, 656,   0, 0, 0, 1};
      vecs[14] = '{  751,  0, 751,   0, 0, 0, 1};
      vecs[15] = '{  752,  0, 752,   0, 0, 1, 1};
      vecs[16] = '{  799,  0, 799,   0, 0, 1, 1};
      vecs[17] = '{  800,  0,   0,   1, 1, 1, 1};
      vecs[18] = '{ 9599,  2, 799,  11, 0, 1, 1};
      vecs[19] = '{ 9600,  2,   0,  12, 0, 1, 1};
      vecs[20] = '{11199,  2, 799,  13, 0, 1, 1};
      vecs[21] = '{11200,  2,   0,  14, 0, 1, 0};
      vecs[22] = '{12799,  2, 799,  15, 0, 1, 0};
      vecs[23] = '{12800,  2,   0,  16, 0, 1, 1};
      vecs[24] = '{15199,  2, 799,  18, 0, 1, 1};
      vecs[25] = '{15200,  2,   0,   0, 1, 1, 1};

      // Hold reset for 5 clocks; outputs sit at the origin with syncs idle.
      repeat (5) begin
         @(posedge clk_pix);
         #1;
      end
      chk("rst_sx",   sx_a, 0);
      chk("rst_sy",   sy_a, 0);
      chk("rst_de",   de_a, 1);
      chk("rst_hs",   hs_a, 1);
      chk("rst_vs",   vs_a, 1);
      chk("rst_hs_c", hs_c, 0);
      chk("rst_vs_b", vs_b, 1);
      chk("rst_sx_b", sx_b, 0);

      rst_a = 1'b1;
      rst_b = 1'b1;
      cyc   = 0;

      // Table-driven checks at hand-computed raster positions.
      for (int i = 0; i < NV; i++) begin
         while (cyc < vecs[i].t) step();
         case (vecs[i].sel)
            0:       begin a_sx = sx_a; a_sy = sy_a; a_de = de_a; a_hs = hs_a; a_vs = vs_a; end
            1:       begin a_sx = sx_c; a_sy = sy_c; a_de = de_c; a_hs = hs_c; a_vs = vs_c; end
            default: begin a_sx = sx_b; a_sy = sy_b; a_de = de_b; a_hs = hs_b; a_vs = vs_b; end
         endcase
         chk($sformatf("vec%0d_sx", i), a_sx, vecs[i].sx);
         chk($sformatf("vec%0d_sy", i), a_sy, vecs[i].sy);
         chk($sformatf("vec%0d_de", i), a_de, int'(vecs[i].de));
         chk($sformatf("vec%0d_hs", i), a_hs, int'(vecs[i].hs));
         chk($sformatf("vec%0d_vs", i), a_vs, int'(vecs[i].vs));
      end

      // Line and frame measurements over two short frames.
      while (cyc < MEAS_END) step();
      chk("line_de_cycles",    de_cnt, 640);
      chk("line_hs_low",       hs_low_cnt, 96);
      chk("half_hs_high",      hs_high_cnt_c, 48);
      chk("hs_fall_count",     n_hfall, 38);
      chk("hs_fall_bad_gap",   bad_hgap, 0);
      chk("vs_fall_count",     n_vfall, 2);
      chk("vs_rise_count",     n_vrise, 2);
      chk("vs_first_fall",     vfall0, 11200);
      chk("vs_fall_gap",       vfall1 - vfall0, 15200);
      chk("frame_vs_low",      vs_low_cnt, 1600);
      chk("de_outside_active", de_bad, 0);

      // Mid-frame reset at (700,15) of the third short frame, both syncs asserted.
      while (cyc < 43100) step();
      chk("pre_rst_sx", sx_b, 700);
      chk("pre_rst_sy", sy_b, 15);
      chk("pre_rst_hs", hs_b, 0);
      chk("pre_rst_vs", vs_b, 0);
      rst_b = 1'b0;
      step();
      chk("mid_rst_sx", sx_b, 0);
      chk("mid_rst_sy", sy_b, 0);
      chk("mid_rst_de", de_b, 1);
      chk("mid_rst_hs", hs_b, 1);
      chk("mid_rst_vs", vs_b, 1);
      rst_b = 1'b1;
      step();
      chk("post_rst_sx", sx_b, 1);
      chk("post_rst_sy", sy_b, 0);
      chk("post_rst_hs", hs_b, 1);
      chk("post_rst_vs", vs_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
